// File: rtl/mem_wb_elastic_reg.sv
// mem_wb_elastic_reg: two-entry elastic MEM/WB pipeline register with flush and async active-low reset.
// Define MEMWB_FWD_EN to add the fwd_valid/fwd_addr/fwd_data forwarding outputs driven from the head entry.
module mem_wb_elastic_reg #(
  parameter int DATA_W = 48,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] RD,
  input  logic [DATA_W-1:0] ALUOutM,
  input  logic [ADDR_W-1:0] WA3M,
  input  logic              PCSrcM,
  input  logic              regWriteM,
  input  logic              memToRegM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ReadData,
  output logic [DATA_W-1:0] AluOutW,
  output logic [ADDR_W-1:0] WA3W,
  output logic              PCSrcW,
  output logic              regWriteW,
  output logic              memToRegW,
  output logic [DATA_W-1:0] ResultW
`ifdef MEMWB_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [ADDR_W-1:0] fwd_addr,
  output logic [DATA_W-1:0] fwd_data
`endif
);
  localparam int EW = 2*DATA_W + ADDR_W + 3;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t        state_q, state_d;
  logic [EW-1:0] head_q, head_d, tail_q, tail_d, in_ent;
  logic          head_we, tail_we, rdy_q, push, pop, pc_h, rw_h;
  assign in_ent    = {RD, ALUOutM, WA3M, PCSrcM, regWriteM, memToRegM};
  // rdy_q holds in_ready low through reset and until the first edge after release
  assign in_ready  = rdy_q && (state_q != FULL);
  assign out_valid = state_q != EMPTY;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_comb begin
    state_d = state_q;
    head_d  = in_ent;
    tail_d  = in_ent;
    head_we = 1'b0;
    tail_we = 1'b0;
    if (flush) state_d = EMPTY;
    else case (state_q)
      EMPTY: begin
        state_d = push ? ONE : EMPTY;
        head_we = push;
      end
      ONE: begin
        state_d = (push && !pop) ? FULL : (pop && !push) ? EMPTY : ONE;
        head_we = push && pop;
        tail_we = push && !pop;
      end
      FULL: begin
        state_d = pop ? ONE : FULL;
        head_d  = tail_q;
        head_we = pop;
      end
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      if (head_we) head_q <= head_d;
      if (tail_we) tail_q <= tail_d;
    end
  end
  assign {ReadData, AluOutW, WA3W, pc_h, rw_h, memToRegW} = head_q;
  assign PCSrcW    = out_valid && pc_h;
  assign regWriteW = out_valid && rw_h;
  assign ResultW   = memToRegW ? ReadData : AluOutW;
`ifdef MEMWB_FWD_EN
  assign fwd_valid = out_valid && regWriteW;
  assign fwd_addr  = WA3W;
  assign fwd_data  = ResultW;
`endif
endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// tb_mem_wb_elastic_reg: directed and random checks of mem_wb_elastic_reg against a queue model.
module tb_mem_wb_elastic_reg;
  localparam int DW = 48;
  localparam int AW = 4;
  typedef struct packed {
    logic [DW-1:0] rd;
    logic [DW-1:0] alu;
    logic [AW-1:0] wa;
    logic          pc;
    logic          rw;
    logic          mr;
  } ent_t;
  logic clk = 1'b0, rst = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, PCSrcW, regWriteW, memToRegW;
  logic PCSrcM = 1'b0, regWriteM = 1'b0, memToRegM = 1'b0;
  logic [DW-1:0] RD = '0, ALUOutM = '0, ReadData, AluOutW, ResultW;
  logic [AW-1:0] WA3M = '0, WA3W;
`ifdef MEMWB_FWD_EN
  logic fwd_valid;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;
`endif
  int total = 0, bad = 0;
  ent_t q[$];
  bit rdy_m = 1'b0;

  mem_wb_elastic_reg #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .RD(RD), .ALUOutM(ALUOutM), .WA3M(WA3M), .PCSrcM(PCSrcM), .regWriteM(regWriteM),
    .memToRegM(memToRegM), .out_valid(out_valid), .out_ready(out_ready),
    .ReadData(ReadData), .AluOutW(AluOutW), .WA3W(WA3W), .PCSrcW(PCSrcW),
    .regWriteW(regWriteW), .memToRegW(memToRegW), .ResultW(ResultW)
`ifdef MEMWB_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    ent_t h;
    logic [DW-1:0] res;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, rdy_m && q.size() < 2);
    if (q.size() > 0) begin
      h = q[0];
      res = h.mr ? h.rd : h.alu;
      chk("ReadData", ReadData, h.rd);
      chk("AluOutW", AluOutW, h.alu);
      chk("WA3W", WA3W, h.wa);
      chk("PCSrcW", PCSrcW, h.pc);
      chk("regWriteW", regWriteW, h.rw);
      chk("memToRegW", memToRegW, h.mr);
      chk("ResultW", ResultW, res);
`ifdef MEMWB_FWD_EN
      chk("fwd_valid", fwd_valid, h.rw);
      chk("fwd_addr", fwd_addr, h.wa);
      chk("fwd_data", fwd_data, res);
`endif
    end else begin
      chk("PCSrcW_idle", PCSrcW, 1'b0);
      chk("regWriteW_idle", regWriteW, 1'b0);
`ifdef MEMWB_FWD_EN
      chk("fwd_valid_idle", fwd_valid, 1'b0);
`endif
    end
  endtask

  task automatic tick();
    bit psh, pp;
    ent_t e;
    psh = in_valid && rdy_m && q.size() < 2;
    pp  = q.size() > 0 && out_ready;
    e   = '{RD, ALUOutM, WA3M, PCSrcM, regWriteM, memToRegM};
    @(posedge clk);
    if (!rst) begin
      q.delete();
      rdy_m = 1'b0;
    end else begin
      if (flush) q.delete();
      else begin
        if (pp) void'(q.pop_front());
        if (psh) q.push_back(e);
      end
      rdy_m = 1'b1;
    end
    @(negedge clk);
    check_all();
  endtask

  task automatic drive(input bit iv, input bit ordy, input bit fl, input logic [DW-1:0] rd,
                       input logic [DW-1:0] alu, input logic [AW-1:0] wa, input bit pc,
                       input bit rw, input bit mr);
    in_valid = iv; out_ready = ordy; flush = fl; RD = rd; ALUOutM = alu; WA3M = wa;
    PCSrcM = pc; regWriteM = rw; memToRegM = mr;
    tick();
  endtask

  task automatic reset_zero_check();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_ReadData", ReadData, '0);
    chk("rst_AluOutW", AluOutW, '0);
    chk("rst_WA3W", WA3W, '0);
    chk("rst_ctrl", {PCSrcW, regWriteW, memToRegW}, 3'b000);
    chk("rst_ResultW", ResultW, '0);
  endtask

  initial begin
    logic [63:0] r1, r2;
    #3 reset_zero_check();
    @(negedge clk);
    rst = 1'b1;
    drive(0, 1, 0, '0, '0, '0, 0, 0, 0);
    // basic push with 1-cycle latency
    drive(1, 1, 0, 48'h123456789ABC, 48'h0BAD, 4'h3, 0, 1, 1);
    chk("basic_result", ResultW, 48'h123456789ABC);
    chk("basic_rw", regWriteW, 1'b1);
    drive(0, 1, 0, '0, '0, '0, 0, 0, 0);
    // backpressure fills both slots, then drains in order
    drive(1, 0, 0, 48'h1, 48'h0, 4'h1, 0, 1, 1);
    drive(1, 0, 0, 48'h2, 48'h0, 4'h2, 1, 1, 1);
    chk("bp_full_in_ready", in_ready, 1'b0);
    chk("bp_head_A", ResultW, 48'h1);
    drive(1, 0, 0, 48'h3, 48'h0, 4'h3, 1, 1, 1);
    chk("bp_hold_A", ResultW, 48'h1);
    drive(0, 1, 0, '0, '0, '0, 0, 0, 0);
    chk("bp_head_B", ResultW, 48'h2);
    drive(0, 1, 0, '0, '0, '0, 0, 0, 0);
    chk("bp_drained", out_valid, 1'b0);
    // simultaneous push and pop in ONE
    drive(1, 0, 0, 48'h0, 48'h5, 4'h5, 0, 1, 0);
    drive(1, 1, 0, 48'h0, 48'h6, 4'h6, 0, 1, 0);
    chk("sim_head", ResultW, 48'h6);
    chk("sim_one_in_ready", in_ready, 1'b1);
    chk("sim_one_valid", out_valid, 1'b1);
    // flush from FULL with coincident push
    drive(1, 0, 0, 48'h7, 48'h0, 4'h7, 1, 1, 1);
    drive(1, 1, 1, 48'h8, 48'h0, 4'h8, 1, 1, 1);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_rw", regWriteW, 1'b0);
    // forwarding-style head (ALU result, register write)
    drive(1, 0, 0, 48'hFFFF, 48'h42, 4'h7, 0, 1, 0);
    chk("fwd_like_result", ResultW, 48'h42);
    // asynchronous reset mid-cycle while FULL
    drive(1, 0, 0, 48'hA, 48'hB, 4'h9, 1, 1, 0);
    chk("pre_rst_full", in_ready, 1'b0);
    #2 rst = 1'b0;
    q.delete();
    rdy_m = 1'b0;
    #1 reset_zero_check();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rst_release_ready", in_ready, 1'b1);
    for (int i = 0; i < 500; i++) begin
      r1 = {$urandom, $urandom};
      r2 = {$urandom, $urandom};
      drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
            r1[DW-1:0], r2[DW-1:0], AW'($urandom), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 1));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
